// File: rtl/encoder42_seq_if.sv
// ============================================================================
// encoder42_seq_if : request/result bus of the registered priority encoder. Rev 1.0
// ============================================================================
`default_nettype none

interface encoder42_seq_if #(
  parameter int N     = 4,
  parameter int W     = 2,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     d;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     code;
  logic             zero;
  logic             multi;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  // Encoder side
  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, code, zero, multi, enc_count, err_count
  );

  // Request source / result consumer side
  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, code, zero, multi, enc_count, err_count
  );
endinterface

`default_nettype wire

// File: rtl/encoder42_seq.sv
// ============================================================================
// encoder42_seq : one-hot to binary priority encoder, 1-deep valid/ready stage. Rev 1.0
// ============================================================================
`default_nettype none

module encoder42_seq #(
  parameter int N     = 4,
  parameter int W     = 2,
  parameter int CNT_W = 8
) (
  input  wire logic            clk,
  input  wire logic            rst,
  encoder42_seq_if.slave       bus
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     code_q, code_d;
  logic             zero_q, zero_d;
  logic             multi_q, multi_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             accept_w;
  logic [W-1:0]     enc_code_w;
  logic             enc_zero_w;
  logic             enc_multi_w;

  assign bus.out_valid = (state_q == FULL);
  assign bus.in_ready  = (state_q == EMPTY) | bus.out_ready;
  assign accept_w      = bus.in_valid & bus.in_ready;

  // Ascending scan so the highest set bit wins.
  always_comb begin
    enc_code_w = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.d[i]) begin
        enc_code_w = W'(i);
      end
    end
  end

  assign enc_zero_w  = (bus.d == '0);
  // Clearing the lowest set bit leaves something only when two or more were set.
  assign enc_multi_w = |(bus.d & (bus.d - N'(1)));

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    zero_d    = zero_q;
    multi_d   = multi_q;
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (accept_w) begin
      state_d = FULL;
      code_d  = enc_code_w;
      zero_d  = enc_zero_w;
      multi_d = enc_multi_w;
      if (enc_cnt_q != '1) begin
        enc_cnt_d = enc_cnt_q + CNT_W'(1);
      end
      if ((enc_zero_w | enc_multi_w) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end else if ((state_q == FULL) && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      code_q    <= '0;
      zero_q    <= 1'b0;
      multi_q   <= 1'b0;
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      zero_q    <= zero_d;
      multi_q   <= multi_d;
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.code      = code_q;
  assign bus.zero      = zero_q;
  assign bus.multi     = multi_q;
  assign bus.enc_count = enc_cnt_q;
  assign bus.err_count = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_encoder42_seq.sv
// ============================================================================
// tb_encoder42_seq : scoreboard bench for encoder42_seq with a behavioural model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_encoder42_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  encoder42_seq_if #(.N(4), .W(2), .CNT_W(8)) bus ();

  encoder42_seq #(.N(4), .W(2), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [1:0] code;
    logic       zero;
    logic       multi;
  } item_t;

  item_t sb[$];
  int    enc_m;
  int    err_m;
  bit    exp_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Code is the largest k with 2^k <= d.
  function automatic item_t ref_model(input logic [3:0] dv);
    item_t r;
    int    v;
    v       = int'(dv);
    r.d     = dv;
    r.zero  = (v == 0);
    r.multi = ($countones(dv) > 1);
    r.code  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (v >= (1 << k)) r.code = 2'(k);
    end
    return r;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Monitor: compares the presented result against the scoreboard head, then
  // records whatever the upcoming edge will accept.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      enc_m = 0;
      err_m = 0;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    end else begin
      exp_ready = (sb.size() == 0) || bus.out_ready;
      check("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
      check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      check("enc_count", 32'(bus.enc_count), 32'(enc_m));
      check("err_count", 32'(bus.err_count), 32'(err_m));
      if (sb.size() != 0) begin
        check("code", 32'(bus.code), 32'(sb[0].code));
        check("zero", 32'(bus.zero), 32'(sb[0].zero));
        check("multi", 32'(bus.multi), 32'(sb[0].multi));
        if (!sb[0].zero && !sb[0].multi) begin
          logic [3:0] dec;
          dec = 4'd1 << bus.code;
          check("loopback", 32'(dec), 32'(sb[0].d));
        end
        if (bus.out_ready) void'(sb.pop_front());
      end
      if (bus.in_valid && exp_ready) begin
        item_t it;
        it = ref_model(bus.d);
        sb.push_back(it);
        enc_m = sat_inc(enc_m);
        if (it.zero || it.multi) err_m = sat_inc(err_m);
      end
    end
  end

  // Drive one cycle: inputs change 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [3:0] dv, input logic ordy);
    bus.in_valid  = v;
    bus.d         = dv;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] onehot [4];
    logic [7:0] base;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid  = 1'b0;
    bus.d         = 4'd0;
    bus.out_ready = 1'b0;
    onehot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    @(posedge clk); @(posedge clk); #1;
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_code", 32'(bus.code), 32'd0);
    check("reset_enc", 32'(bus.enc_count), 32'd0);
    rst = 1'b0;
    step(1'b0, 4'd0, 1'b1);

    // One-hot stream, back-to-back
    for (int i = 0; i < 4; i++) step(1'b1, onehot[i], 1'b1);
    check("onehot_enc", 32'(bus.enc_count), 32'd4);
    check("onehot_err", 32'(bus.err_count), 32'd0);
    check("onehot_last_code", 32'(bus.code), 32'd3);
    step(1'b0, 4'd0, 1'b1);

    // Error vectors
    step(1'b1, 4'b1010, 1'b1);
    check("multi_code", 32'(bus.code), 32'd3);
    check("multi_flag", 32'(bus.multi), 32'd1);
    check("multi_zero", 32'(bus.zero), 32'd0);
    step(1'b1, 4'b0000, 1'b1);
    check("zero_code", 32'(bus.code), 32'd0);
    check("zero_flag", 32'(bus.zero), 32'd1);
    check("zero_err", 32'(bus.err_count), 32'd2);
    step(1'b0, 4'd0, 1'b1);

    // Backpressure hold
    base = bus.enc_count;
    step(1'b1, 4'b0100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b0001, 1'b0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_code", 32'(bus.code), 32'd2);
      check("bp_enc", 32'(bus.enc_count), 32'(base + 8'd1));
    end
    step(1'b1, 4'b0001, 1'b1);
    check("bp_release_code", 32'(bus.code), 32'd0);
    check("bp_release_enc", 32'(bus.enc_count), 32'(base + 8'd2));
    step(1'b0, 4'd0, 1'b1);

    // Saturation
    for (int i = 0; i < 300; i++) step(1'b1, 4'b0000, 1'b1);
    check("sat_enc", 32'(bus.enc_count), 32'd255);
    check("sat_err", 32'(bus.err_count), 32'd255);

    // Async reset with a result in flight
    step(1'b1, 4'b0010, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_code", 32'(bus.code), 32'd0);
    check("arst_flags", 32'({bus.zero, bus.multi}), 32'd0);
    check("arst_enc", 32'(bus.enc_count), 32'd0);
    check("arst_err", 32'(bus.err_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 4'd0, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] rd;
      if ($urandom_range(0, 1) == 0) rd = onehot[$urandom_range(0, 3)];
      else rd = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 3) != 0), rd, 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1);
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
